// File: rtl/mouse_bus_pkg.sv
// mouse_bus_pkg: shared register map, sample layout and packing helper for the mouse bus peripheral
// Sample layout (25 bits): {status[5:0], x[7:0], y[7:0], z[2:0]}, status at the MSBs.
package mouse_bus_pkg;
    localparam int SAMPLE_W = 25;
    localparam logic [7:0] OFS_STATUS = 8'd0;
    localparam logic [7:0] OFS_X      = 8'd1;
    localparam logic [7:0] OFS_Y      = 8'd2;
    localparam logic [7:0] OFS_INFO   = 8'd3;
    localparam logic [7:0] OFS_POP    = 8'd4;
    localparam int Z_LSB  = 0;
    localparam int Z_MSB  = 2;
    localparam int Y_LSB  = 3;
    localparam int Y_MSB  = 10;
    localparam int X_LSB  = 11;
    localparam int X_MSB  = 18;
    localparam int ST_LSB = 19;
    localparam int ST_MSB = 24;

    function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [5:0] status, input logic [7:0] x,
                                                        input logic [7:0] y, input logic [2:0] z);
        return {status, x, y, z};
    endfunction
endpackage

// File: rtl/mouse_bus_peripheral_fifo.sv
// mouse_sample_fifo: circular sample queue with overwrite-newest-on-full and overflow pulse
// Ports: clk/rst (sync active-high), push/pop requests, din sample in,
//        head = oldest entry, count = 0..DEPTH, ovf_set = one-cycle pulse when a push overwrote.
module mouse_sample_fifo
    import mouse_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [SAMPLE_W-1:0] din,
    output logic [SAMPLE_W-1:0] head,
    output logic [2:0]          count,
    output logic                ovf_set
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [2:0] FULL = 3'(DEPTH);

    logic [SAMPLE_W-1:0] mem [2**PW];
    logic [PW-1:0] rd_ptr, wr_ptr, prev_ptr;
    logic do_pop, do_push, overwrite;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle frees a slot, so only a push into a full,
    // non-popping queue overwrites the newest entry.
    always_comb begin
        do_pop    = pop && count != 3'd0;
        overwrite = push && count == FULL && !do_pop;
        do_push   = push && !overwrite;
        prev_ptr  = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
        ovf_set   = overwrite;
        head      = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
        else if (overwrite)
            mem[prev_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_push)
                wr_ptr <= inc(wr_ptr);
            if (do_pop)
                rd_ptr <= inc(rd_ptr);
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end
endmodule

// File: rtl/mouse_bus_peripheral.sv
// mouse_bus_peripheral: queues mouse snapshots and exposes the oldest one as bus read registers with an interrupt
// Ports: CLK/RESET (sync active-high); MOUSE_* snapshot inputs and SEND_INTERRUPT update pulse;
//        BUS_ADDR/BUS_DATA/BUS_WE processor bus (BUS_DATA driven only for one cycle after a read);
//        BUS_INTERRUPT_RAISE/BUS_INTERRUPT_ACK interrupt handshake.
module mouse_bus_peripheral
    import mouse_bus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_X,
    input  logic [7:0] MOUSE_Y,
    input  logic [2:0] MOUSE_Z,
    input  logic       SEND_INTERRUPT,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);
    logic push_d, ovf, armed, rd_en, ovf_set, pop_wr, rd_hit, unused_data;
    logic [7:0] ofs, rd_data, rd_q;
    logic [2:0] count;
    logic [SAMPLE_W-1:0] head, view;

    mouse_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (CLK),
        .rst    (RESET),
        .push   (push_d),
        .pop    (pop_wr),
        .din    (pack_sample(MOUSE_STATUS, MOUSE_X, MOUSE_Y, MOUSE_Z)),
        .head   (head),
        .count  (count),
        .ovf_set(ovf_set)
    );

    // Offsets wrap modulo 256, so a single unsigned compare covers the window.
    assign ofs         = BUS_ADDR - BASE_ADDR;
    assign pop_wr      = BUS_WE && ofs == OFS_POP;
    assign rd_hit      = !BUS_WE && ofs <= OFS_INFO;
    assign view        = (count != 3'd0) ? head : '0;
    assign unused_data = ^BUS_DATA[6:0];

    always_comb begin
        rd_data = (ofs == OFS_STATUS) ? {2'b00, view[ST_MSB:ST_LSB]} :
                  (ofs == OFS_X)      ? view[X_MSB:X_LSB] :
                  (ofs == OFS_Y)      ? view[Y_MSB:Y_LSB] :
                                        {ovf, count, 1'b0, view[Z_MSB:Z_LSB]};
        BUS_INTERRUPT_RAISE = armed && count != 3'd0;
    end

    // The transceiver updates its outputs on the edge that samples SEND_INTERRUPT,
    // so the snapshot is taken one cycle later via push_d.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            push_d <= 1'b0;
            ovf    <= 1'b0;
            armed  <= 1'b1;
            rd_en  <= 1'b0;
            rd_q   <= 8'h00;
        end else begin
            push_d <= SEND_INTERRUPT;
            rd_en  <= rd_hit;
            if (rd_hit)
                rd_q <= rd_data;
            ovf   <= ovf_set || (ovf && !(pop_wr && BUS_DATA[7]));
            armed <= pop_wr || (armed && !(BUS_INTERRUPT_ACK && BUS_INTERRUPT_RAISE));
        end
    end

    assign BUS_DATA = rd_en ? rd_q : 8'bzzzzzzzz;
endmodule

// File: doc/mouse_bus_peripheral.md
# mouse_bus_peripheral

Bus-side consumer of the mouse transceiver. It snapshots the clamped mouse state (status, X, Y, Z) on every transceiver `SEND_INTERRUPT` pulse and queues each snapshot in a small FIFO. The head entry is exposed to the microprocessor as memory-mapped read registers. An interrupt is raised while unread samples exist, and it is acknowledged and re-armed through the standard raise/ack pair.

## Interface
- `BASE_ADDR`, default 8'hA0: bus address of register offset 0.
- `FIFO_DEPTH`, default 4: sample entries; legal range 2..7.
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `MOUSE_STATUS` in 6: transceiver `MouseStatus`.
- `MOUSE_X` in 8: transceiver `MouseX`.
- `MOUSE_Y` in 8: transceiver `MouseY`.
- `MOUSE_Z` in 3: transceiver `MouseZ`.
- `SEND_INTERRUPT` in 1: transceiver one-cycle update pulse.
- `BUS_ADDR` in 8: processor address.
- `BUS_DATA` inout 8: processor data bus; driven only when this block is read, else `z`.
- `BUS_WE` in 1: write strobe, 1 = write.
- `BUS_INTERRUPT_RAISE` out 1: interrupt request.
- `BUS_INTERRUPT_ACK` in 1: interrupt acknowledge from processor.

## Operation
- **Capture.** The transceiver updates X/Y/Z/status on the same edge that samples `SEND_INTERRUPT`. The block therefore delays `SEND_INTERRUPT` by one register, `push_d`, and pushes `{status, X, Y, Z}` (25 bits) on `push_d`.
- **FIFO.** Circular buffer with head/tail pointers and `count` of 0..FIFO_DEPTH. Pointers wrap at FIFO_DEPTH-1 → 0.
- **Push when full:** overwrite the newest entry (tail-1) with the new snapshot and set sticky `OVF`. Positions are absolute, so the latest value is correct.
- **Simultaneous push and pop:**
  - Not full: both occur, and `count` is unchanged.
  - Full: the pop frees a slot, a normal push follows, and `OVF` is not set.
- **Pop on empty** is ignored.
- **Registers**, at BASE_ADDR+offset:
  - 0, read: `{2'b00, head.status}`.
  - 1, read: `head.X`.
  - 2, read: `head.Y`.
  - 3, read: `{OVF, count[2:0], 1'b0, head.Z}`.
  - 4, write (any data): pop the head if non-empty. If `data[7]=1`, also clear `OVF`.
  - Offsets 0–2 read 0 when the FIFO is empty. Offset 3 reads `{OVF, 3'b000, 4'b0}` when empty.
  - Writes to offsets 0–3 are ignored. Offsets 5+ are not decoded; `BUS_DATA` stays `z`.
- **Interrupt.**
  - `BUS_INTERRUPT_RAISE = armed & (count != 0)`, combinational from registers.
  - `BUS_INTERRUPT_ACK` while RAISE is high clears `armed`. ACK while RAISE is low is ignored.
  - A pop sets `armed`. If pop and ACK occur in the same cycle, the pop wins and `armed` = 1.
- **Reset values:** `count` 0, pointers 0, `OVF` 0, `armed` 1, `push_d` 0, RAISE 0, `BUS_DATA` `z`. Reset mid-transaction discards all entries and any pending read drive.

## Timing
- `SEND_INTERRUPT` high in cycle n → `push_d` high in n+1 → entry written at the end of n+1 → `count` and RAISE visible in n+2.
- **Read:** address decoded with `BUS_WE`=0 in cycle n. Data is registered at the end of n and driven on `BUS_DATA` for all of cycle n+1, then released to `z` in n+2 unless another read was decoded in n+1.
- **Pop:** write to offset 4 in cycle n → new head, `count`, and `armed` visible in n+1.
- Throughput is one push and one pop per cycle. There are no stalls.

## Structure
- Package `mouse_bus_pkg` holds:
  - register offsets (`OFS_STATUS`=0, `OFS_X`=1, `OFS_Y`=2, `OFS_INFO`=3, `OFS_POP`=4);
  - `SAMPLE_W` = 25;
  - field slice positions of the packed sample.
- One sub-module, `mouse_sample_fifo`: push/pop/overwrite-on-full, with `count` and an `ovf_set` pulse output.
- The top level holds the bus decode, the read data register, the tristate, the `OVF` and `armed` flags, and `push_d`.

## Test plan
- **Single capture and read.** Inputs status=6'h09, X=80, Y=60, Z=2, one `SEND_INTERRUPT` pulse → RAISE high 2 cycles later. Reads of A0/A1/A2/A3 return 8'h09, 8'h50, 8'h3C, 8'h12, each one cycle after its address.
- **Ack/pop sequencing.** Push 2 samples, then ACK → RAISE low with count=2. Write A4 → RAISE high again and count=1. ACK, write A4 → count=0, RAISE low and stays low.
- **Overflow.** 5 pushes with X=1..5, FIFO_DEPTH=4 → count=4; A3 bit7=1. Popping yields X=1, 2, 3, 5. Write A4 with data 8'h80 → `OVF` clears.
- **Full with simultaneous push/pop.** FIFO full; `push_d` and write A4 in the same cycle → count stays 4, `OVF` stays 0, new tail = new sample.
- **Bus hygiene and empty.** Read A7 or 9F → `BUS_DATA` `z`. Pop on empty → count stays 0. Reads A0–A2 return 0.
- **Reset mid-operation.** 3 entries queued with read pending, assert `RESET` one cycle → count=0, RAISE=0, `BUS_DATA` `z` next cycle, `armed`=1.
